// File: rtl/song_reader_if.sv
// Song reader bus: ROM read port plus the note-player load/done handshake.
// The sequencer drives the master side; ROM and player sit on the slave side.
interface song_reader_if #(
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5
);
    logic [SONG_W+IDX_W-1:0] rom_addr;
    logic [11:0]             rom_data;
    logic [5:0]              note;
    logic [5:0]              duration;
    logic                    new_note;
    logic                    song_done;
    logic                    note_done;

    modport master (
        output rom_addr, note, duration, new_note, song_done,
        input  rom_data, note_done
    );

    modport slave (
        input  rom_addr, note, duration, new_note, song_done,
        output rom_data, note_done
    );
endinterface

// File: rtl/song_reader.sv
// Song reader: walks the selected song's note list in an external ROM and
// hands each note/duration to the note player with a one-cycle load strobe.
// A zero duration terminates a song; a full song of 2**IDX_W entries also ends.
module song_reader #(
    parameter int SONG_W  = 2,
    parameter int IDX_W   = 5,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    song_reader_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        SONG_END
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [1:0]       LAT_TGT  = 2'(ROM_LAT);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [SONG_W-1:0]       song_q;
    logic                    armed;
    logic                    note_done_d;
    logic [1:0]              lat_cnt;
    logic [5:0]              note_q;
    logic [5:0]              duration_q;
    logic                    new_note_q;
    logic                    song_done_q;
    logic [SONG_W+IDX_W-1:0] rom_addr_q;
    logic                    done_rise;

    // Only a rising edge of note_done advances, so a held level is harmless.
    assign done_rise = bus.note_done & ~note_done_d;
    assign idx_nxt   = idx + 1'b1;

    // Outputs are all registered.
    assign bus.rom_addr  = rom_addr_q;
    assign bus.note      = note_q;
    assign bus.duration  = duration_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;

    // Sequencer FSM; priority is reset > pause > song change > done_rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            song_q      <= '0;
            armed       <= 1'b1;
            note_done_d <= 1'b0;
            lat_cnt     <= '0;
            note_q      <= '0;
            duration_q  <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            note_done_d <= bus.note_done;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            // A low play re-arms; a finished song needs play low then high.
            if (!play)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    // idx is kept so a resumed song re-fetches the paused note
                    if (play && armed) begin
                        state      <= FETCH;
                        song_q     <= song;
                        rom_addr_q <= {song, idx};
                        lat_cnt    <= '0;
                    end
                end

                SONG_END: begin
                    idx   <= '0;
                    state <= IDLE;
                    if (play)
                        armed <= 1'b0;
                end

                default: begin
                    if (!play) begin
                        // Pause: the player drops its note, so it replays later.
                        state   <= IDLE;
                        lat_cnt <= '0;
                    end else if (song != song_q) begin
                        // New song restarts at its first entry; pending read is dropped.
                        idx        <= '0;
                        song_q     <= song;
                        rom_addr_q <= {song, {IDX_W{1'b0}}};
                        lat_cnt    <= '0;
                        state      <= FETCH;
                    end else begin
                        case (state)
                            FETCH: begin
                                if (lat_cnt == LAT_TGT) begin
                                    lat_cnt <= '0;
                                    if (bus.rom_data[5:0] == 6'd0) begin
                                        state       <= SONG_END;
                                        song_done_q <= 1'b1;
                                    end else begin
                                        note_q     <= bus.rom_data[11:6];
                                        duration_q <= bus.rom_data[5:0];
                                        new_note_q <= 1'b1;
                                        state      <= ISSUE;
                                    end
                                end else begin
                                    lat_cnt <= lat_cnt + 2'd1;
                                end
                            end

                            ISSUE: state <= WAIT_DONE;

                            WAIT_DONE: begin
                                if (done_rise) begin
                                    if (idx == IDX_LAST) begin
                                        idx         <= '0;
                                        state       <= SONG_END;
                                        song_done_q <= 1'b1;
                                    end else begin
                                        idx        <= idx_nxt;
                                        rom_addr_q <= {song_q, idx_nxt};
                                        lat_cnt    <= '0;
                                        state      <= FETCH;
                                    end
                                end
                            end

                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: two instances (ROM latency 1 and 3) share
// play/song/reset; the latency-1 instance carries the functional checks.
module tb_song_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;

    int errors = 0;
    int checks = 0;
    int n1, n3, cnt, strb;

    logic [11:0] rom [128];
    logic [11:0] p3a, p3b;

    song_reader_if #(.SONG_W(2), .IDX_W(5)) bus1 ();
    song_reader_if #(.SONG_W(2), .IDX_W(5)) bus3 ();

    song_reader #(.SONG_W(2), .IDX_W(5), .ROM_LAT(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .play  (play),
        .song  (song),
        .bus   (bus1.master)
    );

    song_reader #(.SONG_W(2), .IDX_W(5), .ROM_LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .play  (play),
        .song  (song),
        .bus   (bus3.master)
    );

    always #5 clk = ~clk;

    // ROM models with 1 and 3 cycles of read latency
    always @(posedge clk) begin
        bus1.rom_data <= rom[bus1.rom_addr];
        p3a           <= rom[bus3.rom_addr];
        p3b           <= p3a;
        bus3.rom_data <= p3b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input logic v);
        bus1.note_done = v;
        bus3.note_done = v;
    endtask

    // Waits (bounded) for a strobe on the latency-1 instance; current cycle counts.
    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (!bus1.new_note && n < 40) begin
            tick();
            n++;
        end
        if (!bus1.new_note)
            check(tag, bus1.new_note, 1);
    endtask

    // From the ISSUE cycle: step into WAIT_DONE, then a one-cycle done pulse.
    task automatic pulse_done();
        tick();
        set_done(1'b1);
        tick();
        set_done(1'b0);
    endtask

    task automatic count_strobes(input int cycles, output int s);
        s = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (bus1.new_note) s++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_note"},  bus1.note,      0);
        check({tag, "_dur"},   bus1.duration,  0);
        check({tag, "_nn"},    bus1.new_note,  0);
        check({tag, "_sd"},    bus1.song_done, 0);
        check({tag, "_addr"},  bus1.rom_addr,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // song 0: 32 nonzero entries; song 1: two notes + terminator; song 2: notes 40+i
        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        for (int i = 0; i < 32; i++) begin
            rom[i]      = {6'(i), 6'(i + 1)};
            rom[64 + i] = {6'(40 + i), 6'd3};
        end
        rom[32] = {6'd10, 6'd4};
        rom[33] = {6'd12, 6'd2};
        rom[34] = 12'd0;

        reset = 1'b1;
        play  = 1'b0;
        song  = 2'd1;
        set_done(1'b0);
        tick();
        tick();
        check_zero("rst");
        reset = 1'b0;
        tick();

        // Latency: first strobe ROM_LAT+2 edges after play rises
        play = 1'b1;
        n1 = -1; n3 = -1; strb = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus1.new_note) strb++;
            if (bus1.new_note && n1 < 0) n1 = c;
            if (bus3.new_note && n3 < 0) n3 = c;
        end
        check("lat1_cycle", n1, 3);
        check("lat3_cycle", n3, 5);
        check("lat1_once",  strb, 1);
        check("lat1_note",  bus1.note, 10);
        check("lat1_dur",   bus1.duration, 4);
        check("lat3_note",  bus3.note, 10);
        check("lat3_dur",   bus3.duration, 4);

        // Song 1 walk to the terminator
        pulse_done();
        wait_strobe("t1_s2_timeout");
        check("t1_note2", bus1.note, 12);
        check("t1_dur2",  bus1.duration, 2);
        check("t1_addr2", bus1.rom_addr, 33);
        pulse_done();
        cnt = 0; strb = 0;
        while (!bus1.song_done && cnt < 20) begin
            tick();
            cnt++;
            if (bus1.new_note) strb++;
        end
        check("t1_song_done", bus1.song_done, 1);
        check("t1_no_strobe", strb, 0);
        check("t1_end_addr",  bus1.rom_addr, 34);
        tick();
        check("t1_done_pulse", bus1.song_done, 0);
        count_strobes(10, strb);
        check("t1_no_restart", strb, 0);

        // Pause at idx 3 re-issues the same entry
        play = 1'b0;
        song = 2'd0;
        tick();
        play = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_strobe("t3_timeout");
            check("t3_note", bus1.note, i);
            pulse_done();
        end
        wait_strobe("t3_idx3_timeout");
        check("t3_idx3", bus1.note, 3);
        tick();
        play = 1'b0;
        count_strobes(10, strb);
        check("t3_paused", strb, 0);
        play = 1'b1;
        wait_strobe("t3_resume_timeout");
        check("t3_re_note", bus1.note, 3);
        check("t3_re_dur",  bus1.duration, 4);
        check("t3_re_addr", bus1.rom_addr, 3);

        // Song change coinciding with done_rise at idx 5
        pulse_done();
        wait_strobe("t4_idx4_timeout");
        pulse_done();
        wait_strobe("t4_idx5_timeout");
        check("t4_idx5", bus1.note, 5);
        tick();
        song = 2'd2;
        set_done(1'b1);
        tick();
        set_done(1'b0);
        check("t4_addr", bus1.rom_addr, 64);
        wait_strobe("t4_new_timeout");
        check("t4_note", bus1.note, 40);
        check("t4_dur",  bus1.duration, 3);
        check("t4_addr_hold", bus1.rom_addr, 64);

        // Full 32-entry song, no terminator
        play = 1'b0;
        song = 2'd0;
        tick();
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_strobe("t5_timeout");
            check("t5_note", bus1.note, i);
            if (i == 31) check("t5_dur31", bus1.duration, 32);
            pulse_done();
        end
        cnt = 0;
        while (!bus1.song_done && cnt < 10) begin
            tick();
            cnt++;
        end
        check("t5_song_done", bus1.song_done, 1);
        tick();
        count_strobes(10, strb);
        check("t5_no_restart", strb, 0);
        play = 1'b0;
        tick();
        play = 1'b1;
        wait_strobe("t5_restart_timeout");
        check("t5_restart_note", bus1.note, 0);
        check("t5_restart_addr", bus1.rom_addr, 0);

        // Reset in FETCH, then in WAIT_DONE with note_done held high
        pulse_done();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("t6_fetch");
        wait_strobe("t6_a_timeout");
        check("t6_a_note", bus1.note, 0);
        tick();
        set_done(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("t6_wait");
        wait_strobe("t6_b_timeout");
        check("t6_b_note", bus1.note, 0);
        count_strobes(15, strb);
        check("t6_held_no_adv", strb, 0);
        set_done(1'b0);
        tick();
        set_done(1'b1);
        tick();
        set_done(1'b0);
        wait_strobe("t6_c_timeout");
        check("t6_c_note", bus1.note, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
